alu_control_muldiv: RTL and testbench
=====================================

Name: alu_control_muldiv

Overview:
Parametrised successor to the single-cycle ALU control decoder. It keeps the ALUOp/FuncCode to ALU-control decode and extends the funct table with addu/subu/xor/sltu. It adds an iterative multiply/divide unit with HI/LO registers (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) and a stall handshake toward the EX stage. It sits beside the main ALU in EX.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CTL_W, 4, width of alu_ctl.

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  reset; asynchronous and active-low
alu_op  input  2  ALUOp from main control
func_code  input  6  instruction funct field
issue  input  1  valid instruction present in EX this cycle
src_a  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data)
src_b  input  WIDTH  rt operand (divisor / multiplier)
alu_ctl  output  CTL_W  ALU operation select (combinational)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
md_busy  output  1  multiply/divide in progress
md_done  output  1  one-cycle pulse; HI/LO just written by mult/div
stall  output  1  hold EX stage (combinational)

Behaviour:
- Decode is combinational and evaluates every cycle, independent of issue.
  - alu_op=0 -> 2; alu_op=1 -> 6; alu_op=3 -> 15.
  - alu_op=2, by funct: 32/33 -> 2; 34/35 -> 6; 36 -> 0; 37 -> 1; 38 -> 3; 39 -> 12; 42 -> 7; 43 -> 8.
  - alu_op=2, funct 16-19 and 24-27 -> 14 (main ALU idle).
  - Any other funct -> 15.
- MD op = issue && alu_op==2 && funct in {24,25,26,27}. HI/LO op = issue && alu_op==2 && funct in {16,17,18,19}.
- stall = md_busy && (MD op || HI/LO op). Ops with stall=1 are not accepted; EX repeats them.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE, MD op accepted:
  - Latch |src_a| and |src_b| (absolute values for signed ops; raw for multu/divu).
  - Latch result sign (a xor b) and remainder sign (a).
  - Clear count; go MUL or DIV.
  - Divisor==0: go directly to FIN with lo = all ones, hi = src_a. md_busy is high exactly 1 cycle.
- MUL: one shift-add step per cycle. DIV: one restoring shift-subtract step per cycle. After WIDTH steps go to FIN.
- FIN: apply two's-complement sign fix to the 2*WIDTH product (mult), or to quotient/remainder (div). Write hi/lo; go IDLE.
- Timing:
  - md_busy = (state != IDLE); rises on the capture edge.
  - Normal mult/div: md_busy high WIDTH+1 cycles.
  - md_done is high the cycle after the FIN edge. HI/LO are visible that cycle.
- Signed div MIN/-1 -> lo=MIN, hi=0. This falls out of the unsigned core; no special case is needed.
- mthi/mtlo (funct 17/19), accepted in IDLE: write src_a into hi/lo on that edge; no busy, no md_done.
- mfhi/mflo (16/18): no state change; the datapath reads hi/lo directly.
- A new MD op in the same cycle as the FIN edge is stalled. It is accepted the next cycle, in IDLE.
- Reset (any state, mid-operation):
  - state IDLE; hi, lo, count and operand registers = 0; md_busy=0; md_done=0.
  - Any in-flight operation is discarded.
- Width rule: the product is 2*WIDTH bits, hi = upper half. For div, lo = quotient, hi = remainder, and the remainder takes the sign of the dividend.

Test Plan:
- Decode sweep: alu_op=2 with funct 32,33,34,36,37,38,39,42,43,24,5 -> alu_ctl 2,2,6,0,1,3,12,7,8,14,15; alu_op=0/1/3 -> 2/6/15.
- mult src_a=0xFFFFFFFD (-3), src_b=5 -> after 33 busy cycles, md_done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1. Also multu 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE.
- div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. divu 7/2 -> lo=3, hi=1.
- divu 7/0 -> md_busy exactly 1 cycle, then lo=0xFFFFFFFF, hi=7.
- Hazard handling:
  - mflo issued 3 cycles after mult -> stall=1 every cycle until md_done, then 0.
  - mtlo 0x1234 in IDLE -> lo=0x1234 next cycle, stall never asserted.
- Reset mid-mult at busy cycle 10 -> md_busy, md_done, hi and lo go 0 immediately without a clock edge.
- Resume after reset: a fresh mult 6*7 -> lo=42, hi=0.

Source files
------------

// File: rtl/alu_control_muldiv.sv
// ALU control decode plus iterative multiply/divide unit with HI/LO registers.
// The decode is purely combinational. The MD unit runs one shift-add step
// (mult) or one restoring shift-subtract step (div) per cycle on magnitudes,
// then fixes the signs in FIN. EX is stalled while the unit is busy.
//
// state | meaning
// IDLE  | waiting; accepts MD ops and mthi/mtlo
// MUL   | shift-add iteration, WIDTH steps
// DIV   | restoring division iteration, WIDTH steps
// FIN   | sign fix-up and HI/LO write-back
module alu_control_muldiv #(
    parameter int WIDTH = 32,
    parameter int CTL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic             issue,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [CTL_W-1:0] alu_ctl,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy,
    output logic             md_done,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg_res;
    logic                 neg_rem;
    logic                 is_div;

    logic                 md_op;
    logic                 hilo_op;
    logic                 signed_op;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // ALU control decode from ALUOp and funct
    always_comb begin
        alu_ctl = CTL_W'(15);
        case (alu_op)
            2'd0: alu_ctl = CTL_W'(2);
            2'd1: alu_ctl = CTL_W'(6);
            2'd2: begin
                case (func_code)
                    6'd32, 6'd33: alu_ctl = CTL_W'(2);
                    6'd34, 6'd35: alu_ctl = CTL_W'(6);
                    6'd36:        alu_ctl = CTL_W'(0);
                    6'd37:        alu_ctl = CTL_W'(1);
                    6'd38:        alu_ctl = CTL_W'(3);
                    6'd39:        alu_ctl = CTL_W'(12);
                    6'd42:        alu_ctl = CTL_W'(7);
                    6'd43:        alu_ctl = CTL_W'(8);
                    6'd16, 6'd17, 6'd18, 6'd19,
                    6'd24, 6'd25, 6'd26, 6'd27:
                                  alu_ctl = CTL_W'(14);
                    default:      alu_ctl = CTL_W'(15);
                endcase
            end
            default: alu_ctl = CTL_W'(15);
        endcase
    end

    // Op classification, hazard stall and operand magnitudes
    always_comb begin
        md_op     = issue && (alu_op == 2'd2) && (func_code[5:2] == 4'b0110);
        hilo_op   = issue && (alu_op == 2'd2) && (func_code[5:2] == 4'b0100);
        md_busy   = (state != S_IDLE);
        stall     = md_busy && (md_op || hilo_op);
        // funct bit 0 clear selects the signed variant (mult, div)
        signed_op = ~func_code[0];
        abs_a     = (signed_op && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
        abs_b     = (signed_op && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;
    end

    // One iteration step of each datapath, plus the final sign fix-up
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, op_b};
        if (!div_diff[WIDTH])
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        prod_fix  = neg_res ? (~acc + 1'b1) : acc;
        quo_fix   = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // MD sequencer with HI/LO registers and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            count   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            is_div  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (md_op) begin
                        op_a    <= abs_a;
                        op_b    <= abs_b;
                        neg_rem <= signed_op && src_a[WIDTH-1];
                        count   <= '0;
                        is_div  <= func_code[1];
                        if (!func_code[1]) begin
                            acc     <= {{WIDTH{1'b0}}, abs_b};
                            neg_res <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            state   <= S_MUL;
                        end else if (src_b == '0) begin
                            // remainder = |a| re-signed to a, quotient all ones
                            acc     <= {abs_a, {WIDTH{1'b1}}};
                            neg_res <= 1'b0;
                            state   <= S_FIN;
                        end else begin
                            acc     <= {{WIDTH{1'b0}}, abs_a};
                            neg_res <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                            state   <= S_DIV;
                        end
                    end else if (hilo_op) begin
                        if (func_code == 6'd17) hi <= src_a;
                        if (func_code == 6'd19) lo <= src_a;
                    end
                end
                S_MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) state <= S_FIN;
                end
                S_DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    if (is_div) begin
                        lo <= quo_fix;
                        hi <= rem_fix;
                    end else begin
                        lo <= prod_fix[WIDTH-1:0];
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                    md_done <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Testbench for alu_control_muldiv: decode table, mult/div results and
// timing, divide-by-zero, hazard stall, mthi/mtlo, async reset and restart.
module tb_alu_control_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   alu_op;
    logic [5:0]   func_code;
    logic         issue;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [3:0]   alu_ctl;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         md_busy;
    logic         md_done;
    logic         stall;

    int vectors = 0;
    int miscompares = 0;

    alu_control_muldiv #(.WIDTH(W), .CTL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .func_code (func_code),
        .issue     (issue),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_ctl   (alu_ctl),
        .hi        (hi),
        .lo        (lo),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    // Decode table reference
    function automatic logic [3:0] model_ctl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd3) return 4'd15;
        case (f)
            6'd32, 6'd33: return 4'd2;
            6'd34, 6'd35: return 4'd6;
            6'd36: return 4'd0;
            6'd37: return 4'd1;
            6'd38: return 4'd3;
            6'd39: return 4'd12;
            6'd42: return 4'd7;
            6'd43: return 4'd8;
            6'd16, 6'd17, 6'd18, 6'd19, 6'd24, 6'd25, 6'd26, 6'd27: return 4'd14;
            default: return 4'd15;
        endcase
    endfunction

    // Arithmetic reference for mult/multu/div/divu using wide integers
    task automatic model_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] eh, output logic [W-1:0] el);
        longint sa, sb, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = '0;
        el = '0;
        case (f)
            6'd24: begin p = sa * sb; u = p; eh = u[63:32]; el = u[31:0]; end
            6'd25: begin u = {32'b0, a} * {32'b0, b}; eh = u[63:32]; el = u[31:0]; end
            6'd26: begin
                if (b == '0) begin el = '1; eh = a; end
                else begin p = sa / sb; u = p; el = u[31:0]; p = sa % sb; u = p; eh = u[31:0]; end
            end
            default: begin
                if (b == '0) begin el = '1; eh = a; end
                else begin el = a / b; eh = a % b; end
            end
        endcase
    endtask

    task automatic drive_idle();
        issue     = 1'b0;
        alu_op    = 2'd0;
        func_code = 6'd0;
        src_a     = '0;
        src_b     = '0;
    endtask

    task automatic drive_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        issue     = 1'b1;
        alu_op    = 2'd2;
        func_code = f;
        src_a     = a;
        src_b     = b;
    endtask

    // Issue one MD op from IDLE and check busy length, done pulse and result
    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input string name);
        logic [W-1:0] eh, el;
        int exp_busy, busy;
        model_md(f, a, b, eh, el);
        exp_busy = (f[1] && b == '0) ? 1 : W + 1;
        @(negedge clk);
        drive_op(f, a, b);
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL %s issue_stall: got %b expected 0", name, stall);
        end
        @(negedge clk);
        drive_idle();
        busy = 0;
        while (md_busy === 1'b1 && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        vectors++;
        if (busy !== exp_busy) begin
            miscompares++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy, exp_busy);
        end
        vectors++;
        if (md_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s md_done: got %b expected 1", name, md_done);
        end
        vectors++;
        if (hi !== eh || lo !== el) begin
            miscompares++;
            $display("FAIL %s result: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, eh, el);
        end
        @(negedge clk);
        vectors++;
        if (md_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse: got %b expected 0", name, md_done);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || stall !== 1'b0 || hi !== '0 || lo !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b done=%b stall=%b hi=%h lo=%h expected all 0",
                     md_busy, md_done, stall, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_decode();
        logic [5:0] fl [11];
        logic [3:0] el [11];
        logic [1:0] op;
        logic [5:0] f;
        fl = '{6'd32, 6'd33, 6'd34, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd24, 6'd5};
        el = '{4'd2, 4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd12, 4'd7, 4'd8, 4'd14, 4'd15};
        for (int i = 0; i < 11; i++) begin
            alu_op = 2'd2;
            func_code = fl[i];
            #1;
            vectors++;
            if (alu_ctl !== el[i]) begin
                miscompares++;
                $display("FAIL decode_table funct=%0d: got %0d expected %0d", fl[i], alu_ctl, el[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) continue;
            alu_op = 2'(i);
            func_code = 6'd32;
            #1;
            vectors++;
            if (alu_ctl !== (i == 0 ? 4'd2 : (i == 1 ? 4'd6 : 4'd15))) begin
                miscompares++;
                $display("FAIL decode_aluop op=%0d: got %0d", i, alu_ctl);
            end
        end
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            f = 6'($urandom_range(0, 63));
            alu_op = op;
            func_code = f;
            issue = 1'($urandom_range(0, 1));
            #1;
            vectors++;
            if (alu_ctl !== model_ctl(op, f)) begin
                miscompares++;
                $display("FAIL decode_random op=%0d funct=%0d: got %0d expected %0d",
                         op, f, alu_ctl, model_ctl(op, f));
            end
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_md(6'd24, 32'hFFFF_FFFD, 32'd5, "mult_neg3x5");
        run_md(6'd25, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
        for (int i = 0; i < 4; i++)
            run_md(6'(24 + $urandom_range(0, 1)), $urandom, $urandom, "mult_random");
    endtask

    task automatic test_div();
        run_md(6'd26, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
        run_md(6'd26, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
        run_md(6'd27, 32'd7, 32'd2, "divu_7_2");
        run_md(6'd27, 32'd7, 32'd0, "divu_by_zero");
        run_md(6'd26, 32'hFFFF_FFF0, 32'd0, "div_neg_by_zero");
        for (int i = 0; i < 6; i++)
            run_md(6'(26 + $urandom_range(0, 1)), $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31),
                   "div_random");
    endtask

    task automatic test_hazard();
        logic [W-1:0] eh, el;
        model_md(6'd24, 32'd123456, 32'hFFFF_FCEB, eh, el);
        @(negedge clk);
        drive_op(6'd24, 32'd123456, 32'hFFFF_FCEB);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        drive_op(6'd18, 32'd0, 32'd0);
        for (int k = 3; k <= W + 2; k++) begin
            if (k > 3) @(negedge clk);
            #1;
            vectors++;
            if (stall !== (k <= W + 1)) begin
                miscompares++;
                $display("FAIL hazard_stall cycle=%0d: got %b expected %b", k, stall, (k <= W + 1));
            end
        end
        vectors++;
        if (md_done !== 1'b1 || lo !== el || hi !== eh) begin
            miscompares++;
            $display("FAIL hazard_result: got done=%b hi=%h lo=%h expected done=1 hi=%h lo=%h",
                     md_done, hi, lo, eh, el);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        drive_op(6'd19, 32'h0000_1234, 32'd0);
        #1;
        vectors++;
        if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        drive_op(6'd17, 32'hCAFE_0001, 32'd0);
        vectors++;
        if (lo !== 32'h0000_1234 || md_busy !== 1'b0 || md_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo_write: got lo=%h busy=%b done=%b expected lo=00001234 busy=0 done=0",
                     lo, md_busy, md_done);
        end
        @(negedge clk);
        drive_idle();
        vectors++;
        if (hi !== 32'hCAFE_0001 || lo !== 32'h0000_1234 || md_busy !== 1'b0 || md_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_write: got hi=%h lo=%h busy=%b done=%b expected hi=cafe0001 lo=00001234",
                     hi, lo, md_busy, md_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eh1, el1, eh2, el2;
        int busy;
        model_md(6'd25, 32'hDEAD_BEEF, 32'h0000_0101, eh1, el1);
        model_md(6'd26, 32'hFFFF_FF00, 32'd7, eh2, el2);
        @(negedge clk);
        drive_op(6'd25, 32'hDEAD_BEEF, 32'h0000_0101);
        @(negedge clk);
        drive_op(6'd26, 32'hFFFF_FF00, 32'd7);
        for (int k = 1; k <= W + 2; k++) begin
            if (k > 1) @(negedge clk);
            #1;
            vectors++;
            if (stall !== (k <= W + 1)) begin
                miscompares++;
                $display("FAIL b2b_stall cycle=%0d: got %b expected %b", k, stall, (k <= W + 1));
            end
        end
        vectors++;
        if (md_done !== 1'b1 || hi !== eh1 || lo !== el1) begin
            miscompares++;
            $display("FAIL b2b_first: got done=%b hi=%h lo=%h expected done=1 hi=%h lo=%h",
                     md_done, hi, lo, eh1, el1);
        end
        @(negedge clk);
        drive_idle();
        busy = 0;
        while (md_busy === 1'b1 && busy < 200) begin
            busy++;
            @(negedge clk);
        end
        vectors++;
        if (busy !== W + 1 || md_done !== 1'b1 || hi !== eh2 || lo !== el2) begin
            miscompares++;
            $display("FAIL b2b_second: got busy=%0d done=%b hi=%h lo=%h expected busy=%0d done=1 hi=%h lo=%h",
                     busy, md_done, hi, lo, W + 1, eh2, el2);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_op(6'd24, 32'd1000, 32'd3000);
        @(negedge clk);
        drive_idle();
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || hi !== '0 || lo !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected all 0",
                     md_busy, md_done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || hi !== '0 || lo !== '0) begin
            miscompares++;
            $display("FAIL reset_discard: got busy=%b done=%b hi=%h lo=%h expected all 0",
                     md_busy, md_done, hi, lo);
        end
    endtask

    task automatic test_resume();
        run_md(6'd24, 32'd6, 32'd7, "resume_6x7");
        vectors++;
        if (lo !== 32'd42 || hi !== 32'd0) begin
            miscompares++;
            $display("FAIL resume_const: got hi=%h lo=%h expected hi=0 lo=2a", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_hazard();
        test_back_to_back();
        test_mthi_mtlo();
        test_reset_mid();
        test_resume();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
